// File: rtl/led_pkg.sv
// Shared definitions for the switch-to-LED display controller.
// Provides the display mode encodings and the mode field width.
package led_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_PASS  = 2'd0,
      MODE_BLINK = 2'd1,
      MODE_CHASE = 2'd2,
      MODE_COUNT = 2'd3
   } mode_t;

endpackage

// File: rtl/led_debounce.sv
// Switch synchroniser and sample-agreement debouncer.
// Ports: clk, rst (sync, active-high), sw (async raw), db (debounced).
module led_debounce #(
   parameter int WIDTH           = 16,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw,
   output logic [WIDTH-1:0] db
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sw_s;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] agree;
   logic [CW-1:0]    cnt;
   logic             strobe;

   assign sw_s   = sync_q[SYNC_STAGES-1];
   assign strobe = (cnt == CW'(DEBOUNCE_CYCLES - 1));
   // A bit only moves when two consecutive samples agree on it.
   assign agree  = ~(sw_s ^ prev);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++)
            sync_q[i] <= '0;
         cnt  <= '0;
         prev <= '0;
         db   <= '0;
      end else begin
         sync_q[0] <= sw;
         for (int i = 1; i < SYNC_STAGES; i++)
            sync_q[i] <= sync_q[i-1];
         cnt <= strobe ? '0 : cnt + 1'b1;
         if (strobe) begin
            db   <= (db & ~agree) | (sw_s & agree);
            prev <= sw_s;
         end
      end
   end

endmodule

// File: rtl/led_mode_ctrl.sv
// Debounced switch to LED driver with pass/blink/chase/count modes.
// Ports: clk, rst (sync, active-high), sw, mode, led, tick.
module led_mode_ctrl
   import led_pkg::*;
#(
   parameter int WIDTH           = 16,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int TICK_CYCLES     = 25_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  sw,
   input  logic [MODE_W-1:0] mode,
   output logic [WIDTH-1:0]  led,
   output logic              tick
);

   localparam int TW = $clog2(TICK_CYCLES);

   logic [WIDTH-1:0] db;
   logic [WIDTH-1:0] chase;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] led_nxt;
   logic [TW-1:0]    tcnt;
   logic             phase;
   logic             wrap;
   logic             mode_chg;
   mode_t            mode_q;

   led_debounce #(
      .WIDTH           (WIDTH),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_db (
      .clk (clk),
      .rst (rst),
      .sw  (sw),
      .db  (db)
   );

   assign wrap     = (tcnt == TW'(TICK_CYCLES - 1));
   assign mode_chg = (mode_t'(mode) != mode_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q <= MODE_PASS;
         tcnt   <= '0;
         tick   <= 1'b0;
         phase  <= 1'b1;
         chase  <= WIDTH'(1);
         count  <= '0;
         led    <= '0;
      end else begin
         mode_q <= mode_t'(mode);
         // tick still pulses on a colliding mode change
         tick   <= wrap;
         tcnt   <= (wrap || mode_chg) ? '0 : tcnt + 1'b1;
         led    <= led_nxt;
         if (mode_chg) begin
            phase <= 1'b1;
            chase <= WIDTH'(1);
            count <= '0;
         end else if (wrap) begin
            phase <= ~phase;
            chase <= {chase[WIDTH-2:0], chase[WIDTH-1]};
            count <= count + 1'b1;
         end
      end
   end

   always_comb begin
      led_nxt = db;
      unique case (mode_q)
         MODE_PASS:  led_nxt = db;
         MODE_BLINK: led_nxt = phase ? db : '0;
         MODE_CHASE: led_nxt = chase;
         MODE_COUNT: led_nxt = count;
      endcase
   end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Self-checking bench for led_mode_ctrl (WIDTH=8, DEB=4, TICK=8).
// Expected LED values are queued at stimulus time, popped on output.
module tb_led_mode_ctrl;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic [7:0] sw   = 8'h00;
   logic [1:0] mode = 2'd0;
   logic [7:0] led;
   logic       tick;

   int n_run  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int last   = 0;
   logic [7:0] exp_q [$];

   led_mode_ctrl #(
      .WIDTH           (8),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4),
      .TICK_CYCLES     (8)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .sw   (sw),
      .mode (mode),
      .led  (led),
      .tick (tick)
   );

   always #5 clk = ~clk;

   // edges seen since the last reset release
   always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_tick(input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (tick === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("tick_timeout", 0, 1);
   endtask

   // wait for the queued value; only start or target may appear
   task automatic wait_led(input string tag, input int budget,
                           input logic [7:0] start);
      logic [7:0] e;
      int bad;
      e   = exp_q.pop_front();
      bad = 0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (led !== start && led !== e) bad++;
         if (led === e) break;
      end
      chk(tag, led, e);
      chk({tag, "_interm"}, bad, 0);
   endtask

   task automatic tick_seq(input string tag, input int n,
                           input bit per);
      for (int k = 0; k < n; k++) begin
         wait_tick(10);
         chk(tag, led, exp_q.pop_front());
         if (per && k > 0) chk({tag, "_period"}, cyc - last, 8);
         last = cyc;
      end
   endtask

   initial begin
      int bad7;

      // 1: reset with switches high
      rst = 1'b1;
      sw  = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_led", led, 8'h00);
         chk("rst_tick", tick, 0);
      end
      rst = 1'b0;
      exp_q.push_back(8'hFF);
      wait_led("rst_pass", 11, 8'h00);

      // 2: stable step 0x00 -> 0x0F
      sw = 8'h00;
      step(12);
      chk("pass_zero", led, 8'h00);
      sw = 8'h0F;
      exp_q.push_back(8'h0F);
      wait_led("deb_stable", 11, 8'h00);
      step(4);
      chk("deb_hold", led, 8'h0F);

      // 3: two-cycle glitch on sw[7] between strobes
      for (int i = 0; i < 4 && (cyc % 4) != 2; i++) step();
      chk("glitch_align", cyc % 4, 2);
      sw = 8'h8F;
      step(2);
      sw = 8'h0F;
      bad7 = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         if (led[7] !== 1'b0) bad7++;
      end
      chk("glitch_bit7", bad7, 0);
      chk("glitch_led", led, 8'h0F);

      // 4: chase over nine ticks
      sw   = 8'hA5;
      mode = 2'd2;
      for (int k = 0; k < 9; k++) exp_q.push_back(8'(1 << (k % 8)));
      step();
      tick_seq("chase", 9, 1'b1);

      // 5: count through wrap, then colliding mode change
      mode = 2'd3;
      for (int k = 0; k < 258; k++) exp_q.push_back(8'(k % 256));
      step();
      tick_seq("count", 258, 1'b1);
      step(7);
      mode = 2'd2;
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h01);
      step();
      chk("chg_tick", tick, 1);
      last = cyc;
      step();
      chk("chg_led", led, exp_q.pop_front());
      wait_tick(10);
      chk("chg_period", cyc - last, 8);
      chk("chg_no_adv", led, exp_q.pop_front());

      // 6: blink on db=0xA5, then mid-period reset
      mode = 2'd1;
      for (int k = 0; k < 4; k++) exp_q.push_back((k % 2) ? 8'h00 : 8'hA5);
      step(2);
      chk("blink_start", led, 8'hA5);
      tick_seq("blink", 4, 1'b1);
      step(3);
      rst  = 1'b1;
      mode = 2'd0;
      step();
      chk("rst_mid_led", led, 8'h00);
      chk("rst_mid_tick", tick, 0);
      rst = 1'b0;
      wait_tick(12);
      chk("tick_restart", cyc, 8);
      exp_q.push_back(8'hA5);
      wait_led("pass_after_rst", 12, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/led_mode_ctrl.md
Name: led_mode_ctrl

Overview:
- Parametrised next-generation switch-to-LED driver for the Basys3 board.
- Synchronises and debounces the slide switches, then drives the LEDs in one of four selectable display modes: pass-through, blink-masked, chase, binary count.
- Sits directly between the top-level sw/led pins. All animation is timed from an internal prescaled tick.

Parameters:
- WIDTH, 16: number of switch/LED channels. Range 2..32.
- SYNC_STAGES, 2: flip-flop stages in the input synchroniser. Minimum 2.
- DEBOUNCE_CYCLES, 1_000_000: clk cycles between debounce samples (10 ms at 100 MHz). Minimum 2.
- TICK_CYCLES, 25_000_000: clk cycles per animation tick (4 Hz at 100 MHz). Minimum 2.

Ports:
- clk  in  1  system clock, 100 MHz. The block has one clock.
- rst  in  1  reset. Synchronous, active-high.
- sw  in  WIDTH  raw slide switches. Asynchronous to clk.
- mode  in  2  display mode select. Synchronous to clk. 0 = PASS, 1 = BLINK, 2 = CHASE, 3 = COUNT.
- led  out  WIDTH  LED drive. Registered.
- tick  out  1  one-cycle pulse each animation tick. Registered.

Behaviour:
- Reset, sampled on a clk edge while rst = 1:
  - led = 0, tick = 0.
  - Synchroniser flops = 0, debounced state db = 0, previous-sample register = 0.
  - Both prescaler counters = 0.
  - chase = 1 (bit 0 set), count = 0, blink phase = 1, registered mode = PASS.
- Reset has priority over every other event. Reset mid-animation or mid-debounce discards all in-flight state.
- Synchroniser: sw passes through SYNC_STAGES flops to give sw_s.
- Debounce sampling:
  - A sample strobe fires when the sample counter reaches DEBOUNCE_CYCLES-1. The counter then wraps to 0.
  - On each strobe, sw_s is compared with the previous sample.
  - For each bit where the two agree, db takes that value. The previous sample is then updated with sw_s.
  - Consequence: a bit that bounces within one sample period never changes db. A stable change reaches db after 2 strobes at most.
- Tick prescaler: counts 0..TICK_CYCLES-1. tick = 1 for exactly the cycle in which the counter wraps.
- Mode register:
  - mode is registered every cycle.
  - When the registered value differs from its previous value: chase resets to 1, count resets to 0, blink phase resets to 1, and the tick prescaler restarts at 0.
  - These restarts take effect on the same edge the new mode is registered.
- On each tick:
  - Blink phase toggles.
  - chase rotates left by one; bit WIDTH-1 wraps to bit 0.
  - count increments modulo 2^WIDTH; all-ones wraps to 0.
  - These states advance in every mode, not only the selected one.
- led, registered one cycle after the source value:
  - PASS: led = db.
  - BLINK: led = db when the phase is 1, otherwise 0.
  - CHASE: led = chase.
  - COUNT: led = count[WIDTH-1:0].
- Simultaneous mode change and tick on the same edge: the mode-change restart wins and the tick has no effect. The tick output is still asserted for that cycle.
- PASS latency, from a stable sw edge to led: SYNC_STAGES + 1 cycles, plus up to 2×DEBOUNCE_CYCLES.

Decomposition:
- Package led_pkg:
  - mode encodings MODE_PASS, MODE_BLINK, MODE_CHASE, MODE_COUNT.
  - 2-bit mode width constant.
- Sub-module led_debounce, parameters WIDTH, SYNC_STAGES, DEBOUNCE_CYCLES.
  - Contains the synchroniser, sample counter and agreement logic.
  - Ports: clk, rst, sw, db.
- The top level holds the tick prescaler, the mode register and the output mux.

Test Plan:
All scenarios use WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, TICK_CYCLES=8.

1. Reset: drive sw=0xFF with rst=1 for 3 cycles, then release.
   - led=0x00 and tick=0 while rst is high.
   - In PASS mode, led becomes 0xFF within 2+1+8 cycles after release.
2. Debounce, stable change: sw steps from 0x00 to 0x0F and holds.
   - led=0x0F within 11 cycles and never takes an intermediate value.
3. Debounce, glitch: pulse sw[7] high for 2 cycles, aligned between strobes.
   - led[7] stays 0 throughout.
4. CHASE: mode=2, observe 9 ticks.
   - led sequence 0x01, 0x02, 0x04, …, 0x80, then 0x01 (wrap).
   - tick period is exactly 8 cycles.
5. COUNT wrap plus mode change:
   - mode=3 for 258 ticks: led steps 0x00, 0x01, …, 0xFF, 0x00, 0x01.
   - Switch to mode=2 on the same edge as a tick: led=0x01 and the next tick occurs 8 cycles later.
6. BLINK plus mid-run reset:
   - mode=1 with db=0xA5: led alternates 0xA5 and 0x00 every 8 cycles, starting at 0xA5.
   - Assert rst mid-period: led=0x00 next cycle, and the prescaler restarts from 0 after release.
